mux_equiv_sweep_ctrl: RTL and testbench

//  Exhaustive equivalence-check sequencer for the evolved-vs-golden mux comparison.
//  - On a start request it drives every input vector into both the evolved candidate
//    and the golden AST mux.
//  - It samples both outputs after a settle delay, counts mismatches and latches the

---
 rtl/mux_equiv_sweep_ctrl_if.sv | 36 +++
 rtl/mux_equiv_sweep_ctrl.sv | 154 +++++++++++++++
 tb/tb_mux_equiv_sweep_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_equiv_sweep_ctrl_if.sv
// Bus between the mux equivalence sweep controller and its surroundings.
// It carries the start request, the candidate/golden mux outputs, the swept
// vector, the result flags and counters, and the verdict byte handshake to
// the UART transmitter.
//   master : the sweep controller (drives vec_out, results and tx_*)
//   slave  : the environment (drives start, cand_out, gold_out, tx_ready)
interface mux_equiv_sweep_ctrl_if #(
  parameter int N_IN  = 3,
  parameter int CNT_W = N_IN + 1
);
  logic             start;
  logic             cand_out;
  logic             gold_out;
  logic [N_IN-1:0]  vec_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [N_IN-1:0]  first_fail;
  logic             fail_valid;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    input  start, cand_out, gold_out, tx_ready,
    output vec_out, busy, done, pass, mismatch_cnt, first_fail, fail_valid,
           tx_data, tx_valid
  );

  modport slave (
    output start, cand_out, gold_out, tx_ready,
    input  vec_out, busy, done, pass, mismatch_cnt, first_fail, fail_valid,
           tx_data, tx_valid
  );
endinterface

// File: rtl/mux_equiv_sweep_ctrl.sv
// Exhaustive equivalence sweep of an evolved mux candidate against the
// golden mux. Every input vector is driven for SETTLE cycles, then both
// outputs are compared; mismatches are counted, the first failing vector is
// latched, and a verdict byte {pass, sat7(count)} is offered to the UART.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : master side of mux_equiv_sweep_ctrl_if (start, cand/gold inputs,
//          vec_out, busy/done/pass, mismatch_cnt, first_fail/fail_valid,
//          tx_data/tx_valid/tx_ready)
//
// state  | meaning
// IDLE   | after reset, waiting for start
// WAIT   | holding vec_out while the muxes settle
// SAMPLE | compare cand_out vs gold_out for the current vector
// REPORT | verdict byte offered, waiting for tx_ready
// DONE   | results frozen, start launches a fresh sweep
module mux_equiv_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2,
  parameter int CNT_W  = N_IN + 1
) (
  input logic                  clk,
  input logic                  rst,
  mux_equiv_sweep_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SAMPLE, S_REPORT, S_DONE} state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [CNT_W-1:0] mc_q, mc_d;
  logic [N_IN-1:0]  ff_q, ff_d;
  logic             fv_q, fv_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [7:0]       txd_q, txd_d;
  logic             txv_q, txv_d;

  logic             mism;
  logic [CNT_W-1:0] mc_inc;

  function automatic logic [6:0] sat7(input logic [CNT_W-1:0] x);
    if (32'(x) > 32'd127) return 7'd127;
    return 7'(x);
  endfunction

  assign mism   = bus.cand_out != bus.gold_out;
  // Count including the current sample so the verdict byte formed on the
  // last vector already reflects a mismatch found there.
  assign mc_inc = mc_q + CNT_W'(mism);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    mc_d     = mc_q;
    ff_d     = ff_q;
    fv_d     = fv_q;
    pass_d   = pass_q;
    done_d   = done_q;
    busy_d   = busy_q;
    txd_d    = txd_q;
    txv_d    = txv_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          mc_d     = '0;
          fv_d     = 1'b0;
          ff_d     = '0;
          pass_d   = 1'b0;
          done_d   = 1'b0;
          vec_d    = '0;
          busy_d   = 1'b1;
          settle_d = SETTLE_M1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (settle_q == 4'd0) state_d = S_SAMPLE;
        else                  settle_d = settle_q - 4'd1;
      end
      S_SAMPLE: begin
        mc_d = mc_inc;
        if (mism && !fv_q) begin
          ff_d = vec_q;
          fv_d = 1'b1;
        end
        if (&vec_q) begin
          txd_d   = {(mc_inc == '0), sat7(mc_inc)};
          txv_d   = 1'b1;
          state_d = S_REPORT;
        end else begin
          vec_d    = vec_q + N_IN'(1);
          settle_d = SETTLE_M1;
          state_d  = S_WAIT;
        end
      end
      S_REPORT: begin
        if (txv_q && bus.tx_ready) begin
          txv_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (mc_q == '0);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      mc_q     <= '0;
      ff_q     <= '0;
      fv_q     <= 1'b0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      txd_q    <= '0;
      txv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      mc_q     <= mc_d;
      ff_q     <= ff_d;
      fv_q     <= fv_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      txd_q    <= txd_d;
      txv_q    <= txv_d;
    end
  end

  assign bus.vec_out      = vec_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.mismatch_cnt = mc_q;
  assign bus.first_fail   = ff_q;
  assign bus.fail_valid   = fv_q;
  assign bus.tx_data      = txd_q;
  assign bus.tx_valid     = txv_q;

endmodule

// File: tb/tb_mux_equiv_sweep_ctrl.sv
module tb_mux_equiv_sweep_ctrl;
  localparam int N_IN  = 3;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] gold_tt;
  logic [7:0] tt_a, tt_b;
  logic start_a, start_b, rdy_a, rdy_b;
  int cur;

  mux_equiv_sweep_ctrl_if #(.N_IN(N_IN), .CNT_W(CNT_W)) ifa ();
  mux_equiv_sweep_ctrl_if #(.N_IN(N_IN), .CNT_W(CNT_W)) ifb ();

  assign ifa.start    = start_a;
  assign ifa.tx_ready = rdy_a;
  assign ifa.cand_out = tt_a[ifa.vec_out];
  assign ifa.gold_out = gold_tt[ifa.vec_out];
  assign ifb.start    = start_b;
  assign ifb.tx_ready = rdy_b;
  assign ifb.cand_out = tt_b[ifb.vec_out];
  assign ifb.gold_out = gold_tt[ifb.vec_out];

  mux_equiv_sweep_ctrl #(.N_IN(N_IN), .SETTLE(2), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.master));
  mux_equiv_sweep_ctrl #(.N_IN(N_IN), .SETTLE(1), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.master));

  logic [2:0] o_vec, o_ff;
  logic [3:0] o_mc;
  logic [7:0] o_txd;
  logic o_busy, o_done, o_pass, o_fv, o_txv;

  always_comb begin
    o_vec  = (cur != 0) ? ifb.vec_out      : ifa.vec_out;
    o_ff   = (cur != 0) ? ifb.first_fail   : ifa.first_fail;
    o_mc   = (cur != 0) ? ifb.mismatch_cnt : ifa.mismatch_cnt;
    o_txd  = (cur != 0) ? ifb.tx_data      : ifa.tx_data;
    o_busy = (cur != 0) ? ifb.busy         : ifa.busy;
    o_done = (cur != 0) ? ifb.done         : ifa.done;
    o_pass = (cur != 0) ? ifb.pass         : ifa.pass;
    o_fv   = (cur != 0) ? ifb.fail_valid   : ifa.fail_valid;
    o_txv  = (cur != 0) ? ifb.tx_valid     : ifa.tx_valid;
  end

  typedef struct {
    int         which;
    logic [7:0] tt;
    int         delay;
    bit         ign;
    int         mc;
    int         ff;
    bit         fv;
    logic [7:0] tx;
    bit         pass;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (cur != 0) start_b = v; else start_a = v;
  endtask

  task automatic set_rdy(input bit v);
    if (cur != 0) rdy_b = v; else rdy_a = v;
  endtask

  // Reference: compare truth tables vector by vector.
  task automatic model(input logic [7:0] tt, output int mc, output int ff, output bit fv,
                       output logic [7:0] tx, output bit pass);
    mc = 0; ff = 0; fv = 0;
    for (int v = 0; v < 8; v++) begin
      if (tt[v] != gold_tt[v]) begin
        if (!fv) begin ff = v; fv = 1; end
        mc++;
      end
    end
    pass = (mc == 0);
    tx = {pass, 7'((mc > 127) ? 127 : mc)};
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vec"},  32'(o_vec), 32'd0);
    chk({tag, "_mc"},   32'(o_mc), 32'd0);
    chk({tag, "_ff"},   32'(o_ff), 32'd0);
    chk({tag, "_fv"},   32'(o_fv), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_pass"}, 32'(o_pass), 32'd0);
    chk({tag, "_txd"},  32'(o_txd), 32'd0);
    chk({tag, "_txv"},  32'(o_txv), 32'd0);
  endtask

  task automatic run_sweep(input int which, input logic [7:0] tt, input int delay,
                           input bit ign, input bit rnd_rdy, input int e_mc, input int e_ff,
                           input bit e_fv, input logic [7:0] e_tx, input bit e_pass);
    int cyc;
    int e_cyc;
    cur = which;
    if (which != 0) tt_b = tt; else tt_a = tt;
    e_cyc = 8 * (((which != 0) ? 1 : 2) + 1);
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    chk("busy_at_start", 32'(o_busy), 32'd1);
    chk("done_cleared", 32'(o_done), 32'd0);
    cyc = 0;
    while (!o_txv && cyc < 400) begin
      set_start(ign && (cyc == 5 || cyc == 12));
      if (rnd_rdy) set_rdy(1'($urandom_range(0, 1)));
      @(negedge clk);
      cyc++;
    end
    set_start(1'b0);
    chk("cycles_to_report", 32'(cyc), 32'(e_cyc));
    chk("report_txd", 32'(o_txd), 32'(e_tx));
    chk("report_mc", 32'(o_mc), 32'(e_mc));
    chk("report_fv", 32'(o_fv), 32'(e_fv));
    chk("report_ff", 32'(o_ff), 32'(e_ff));
    chk("report_vec", 32'(o_vec), 32'd7);
    chk("report_busy", 32'(o_busy), 32'd1);
    set_rdy(delay == 0);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("hold_txv", 32'(o_txv), 32'd1);
      chk("hold_txd", 32'(o_txd), 32'(e_tx));
    end
    if (delay > 0) set_rdy(1'b1);
    @(negedge clk);
    set_rdy(1'b0);
    chk("done_set", 32'(o_done), 32'd1);
    chk("busy_clr", 32'(o_busy), 32'd0);
    chk("txv_clr", 32'(o_txv), 32'd0);
    chk("pass", 32'(o_pass), 32'(e_pass));
    repeat (3) @(negedge clk);
    chk("done_frozen", 32'({o_done, o_mc, o_vec, o_fv}), 32'({1'b1, 4'(e_mc), 3'd7, e_fv}));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int mc, ff;
    bit fv, pass;
    logic [7:0] tx, tt;
    logic [2:0] vb;

    for (int v = 0; v < 8; v++) begin
      vb = 3'(v);
      gold_tt[v] = vb[2] ? vb[1] : vb[0];
    end

    tbl[0] = '{0, 8'hCA, 0,  1'b0, 0, 0, 1'b0, 8'h80, 1'b1};
    tbl[1] = '{0, 8'h00, 0,  1'b0, 4, 1, 1'b1, 8'h04, 1'b0};
    tbl[2] = '{0, 8'hCA, 10, 1'b0, 0, 0, 1'b0, 8'h80, 1'b1};
    tbl[3] = '{0, 8'hCA, 1,  1'b1, 0, 0, 1'b0, 8'h80, 1'b1};
    tbl[4] = '{1, 8'h35, 0,  1'b0, 8, 0, 1'b1, 8'h08, 1'b0};
    tbl[5] = '{1, 8'h35, 2,  1'b0, 8, 0, 1'b1, 8'h08, 1'b0};
    tbl[6] = '{0, 8'h4A, 0,  1'b0, 1, 7, 1'b1, 8'h01, 1'b0};
    tbl[7] = '{1, 8'hCB, 0,  1'b0, 1, 0, 1'b1, 8'h01, 1'b0};

    cur = 0;
    start_a = 0; start_b = 0; rdy_a = 0; rdy_b = 0;
    tt_a = 8'hCA; tt_b = 8'hCA;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_a");
    cur = 1;
    check_all_zero("reset_b");
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_sweep(tbl[i].which, tbl[i].tt, tbl[i].delay, tbl[i].ign, 1'b0,
                tbl[i].mc, tbl[i].ff, tbl[i].fv, tbl[i].tx, tbl[i].pass);

    // Reset mid-sweep with two mismatches already logged.
    cur = 0;
    tt_a = 8'h00;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    c = 0;
    while (o_vec != 3'd5 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("reach_vec5", 32'(o_vec), 32'd5);
    chk("mid_mc", 32'(o_mc), 32'd2);
    chk("mid_ff", 32'(o_ff), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, 8'hCA, 0, 1'b0, 1'b0, 0, 0, 1'b0, 8'h80, 1'b1);

    // Reset while a verdict byte is being offered.
    cur = 1;
    tt_b = 8'h35;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    c = 0;
    while (!o_txv && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("report_reached", 32'(o_txv), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_report");
    @(negedge clk);
    rst = 1'b0;
    run_sweep(1, 8'hCA, 0, 1'b0, 1'b0, 0, 0, 1'b0, 8'h80, 1'b1);

    // Randomized candidates against the truth-table reference.
    for (int i = 0; i < 20; i++) begin
      tt = 8'($urandom);
      model(tt, mc, ff, fv, tx, pass);
      run_sweep(int'($urandom_range(0, 1)), tt, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'b1, mc, ff, fv, tx, pass);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
